// File: rtl/scan_tex_loader.sv
// Scan-chain texture loader: synchronises a two-phase serial frame from the pads
// and commits it as a bank/address/data write through a ready/valid port.
module scan_tex_loader #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int NUM_BANKS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                scan_phi1,
    input  logic                                                scan_phi2,
    input  logic                                                scan_in,
    input  logic                                                scan_load,
    output logic                                                scan_out,
    output logic                                                wr_valid,
    input  logic                                                wr_ready,
    output logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] wr_bank,
    output logic [ADDR_W-1:0]                                   wr_addr,
    output logic [DATA_W-1:0]                                   wr_data,
    output logic                                                busy,
    output logic                                                burst,
    output logic                                                err_len,
    output logic                                                err_ovf,
    input  logic                                                err_clr
);
    localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int BANK_OW = (BANK_W > 0) ? BANK_W : 1;
    localparam int FRAME_W = 1 + BANK_W + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(DATA_W);

    logic [3:0]         sync_r [SYNC_STAGES];
    logic [2:0]         prev_r;
    logic [2:0]         edge_r;
    logic               din_r;
    logic               master_r;
    logic [FRAME_W-1:0] shift_r;
    logic [CNT_W-1:0]   count_r;
    logic               burst_r;
    logic               wr_valid_r;
    logic               err_len_r;
    logic               err_ovf_r;
    logic [BANK_OW-1:0] wr_bank_r;
    logic [ADDR_W-1:0]  wr_addr_r;
    logic [DATA_W-1:0]  wr_data_r;

    logic [3:0]         synced_s;
    logic               phi1_s;
    logic               phi2_s;
    logic               load_s;
    logic               master_next_s;
    logic [BANK_OW-1:0] bank_field_s;

    assign synced_s              = sync_r[SYNC_STAGES-1];
    assign {load_s, phi2_s, phi1_s} = edge_r;
    // A phi1 capture in the same cycle as a shift feeds the freshly captured bit.
    assign master_next_s = phi1_s ? din_r : master_r;

    if (BANK_W > 0) begin : g_bank
        assign bank_field_s = shift_r[ADDR_W+DATA_W +: BANK_OW];
    end else begin : g_nobank
        assign bank_field_s = 1'b0;
    end

    // Pad synchroniser chains, bit order {load, phi2, phi1, in}.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 4'b0000;
        end else begin
            sync_r[0] <= {scan_load, scan_phi2, scan_phi1, scan_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    // Registered rising-edge detection; data bit is delayed to stay aligned with the strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_r <= 3'b000;
            edge_r <= 3'b000;
            din_r  <= 1'b0;
        end else begin
            prev_r <= synced_s[3:1];
            edge_r <= synced_s[3:1] & ~prev_r;
            din_r  <= synced_s[0];
        end
    end

    // Shift path, load decode, write handshake and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            master_r   <= 1'b0;
            shift_r    <= '0;
            count_r    <= '0;
            burst_r    <= 1'b0;
            wr_valid_r <= 1'b0;
            err_len_r  <= 1'b0;
            err_ovf_r  <= 1'b0;
            wr_bank_r  <= '0;
            wr_addr_r  <= '0;
            wr_data_r  <= '0;
        end else begin
            if (phi1_s) master_r <= din_r;
            if (phi2_s) begin
                shift_r <= {shift_r[FRAME_W-2:0], master_next_s};
                if (count_r != FULL_CNT) count_r <= count_r + CNT_W'(1);
            end
            if (wr_valid_r && wr_ready) wr_valid_r <= 1'b0;
            // Clear first so that an error raised in the same cycle wins.
            if (err_clr) begin
                err_len_r <= 1'b0;
                err_ovf_r <= 1'b0;
            end
            if (load_s) begin
                count_r <= '0;
                if (wr_valid_r) begin
                    err_ovf_r <= 1'b1;
                end else if (count_r == FULL_CNT) begin
                    burst_r    <= shift_r[FRAME_W-1];
                    wr_bank_r  <= bank_field_s;
                    wr_addr_r  <= shift_r[DATA_W +: ADDR_W];
                    wr_data_r  <= shift_r[DATA_W-1:0];
                    wr_valid_r <= 1'b1;
                end else if (burst_r && (count_r == BURST_CNT)) begin
                    wr_addr_r  <= wr_addr_r + ADDR_W'(1);
                    wr_data_r  <= shift_r[DATA_W-1:0];
                    wr_valid_r <= 1'b1;
                end else begin
                    err_len_r <= 1'b1;
                    burst_r   <= 1'b0;
                end
            end
        end
    end

    assign scan_out = shift_r[FRAME_W-1];
    assign wr_valid = wr_valid_r;
    assign busy     = wr_valid_r;
    assign burst    = burst_r;
    assign err_len  = err_len_r;
    assign err_ovf  = err_ovf_r;
    assign wr_bank  = wr_bank_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
endmodule

// File: tb/tb_scan_tex_loader.sv
// Randomised bench for scan_tex_loader (4 banks) against a frame-level reference model.
module tb_scan_tex_loader;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int NB = 4;
    localparam int BW = 2;
    localparam int SS = 2;
    localparam int F  = 1 + BW + AW + DW;
    localparam int PW = BW + AW + DW;

    logic clk = 1'b0, rst_n = 1'b0;
    logic phi1 = 1'b0, phi2 = 1'b0, sin = 1'b0, load = 1'b0;
    logic wr_ready = 1'b1, err_clr = 1'b0;
    logic scan_out, wr_valid, busy, burst, err_len, err_ovf;
    logic [BW-1:0] wr_bank;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: the last F bits shifted, bits since last load, burst context.
    logic [F-1:0]  m_frame;
    int            m_count;
    logic          m_burst, m_err_len, m_err_ovf;
    logic [BW-1:0] m_bank;
    logic [AW-1:0] m_addr;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] mon_exp;

    scan_tex_loader #(.ADDR_W(AW), .DATA_W(DW), .NUM_BANKS(NB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .scan_phi1(phi1), .scan_phi2(phi2), .scan_in(sin),
        .scan_load(load), .scan_out(scan_out), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .burst(burst),
        .err_len(err_len), .err_ovf(err_ovf), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Write monitor: a handshake seen here completes on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && wr_valid && wr_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write got %h/%h/%h, none expected", wr_bank, wr_addr, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({wr_bank, wr_addr, wr_data} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL write_payload got %h want %h", {wr_bank, wr_addr, wr_data}, mon_exp);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic void model_reset();
        m_frame = '0; m_count = 0; m_burst = 1'b0;
        m_err_len = 1'b0; m_err_ovf = 1'b0; m_bank = '0; m_addr = '0;
    endfunction

    function automatic void model_shift(input logic b);
        m_frame = {m_frame[F-2:0], b};
        if (m_count < F) m_count++;
    endfunction

    function automatic void model_load(input logic busy_now);
        if (busy_now) begin
            m_err_ovf = 1'b1;
        end else if (m_count == F) begin
            m_burst = m_frame[F-1];
            m_bank  = m_frame[AW+DW +: BW];
            m_addr  = m_frame[DW +: AW];
            exp_q.push_back({m_bank, m_addr, m_frame[DW-1:0]});
        end else if (m_burst && m_count == DW) begin
            m_addr = m_addr + AW'(1);
            exp_q.push_back({m_bank, m_addr, m_frame[DW-1:0]});
        end else begin
            m_err_len = 1'b1;
            m_burst   = 1'b0;
        end
        m_count = 0;
    endfunction

    task automatic shift_bit(input logic b, input logic coinc);
        sin = b;
        tick(3);
        if (coinc) begin
            phi1 = 1'b1; phi2 = 1'b1; tick(3);
            phi1 = 1'b0; phi2 = 1'b0; tick(3);
        end else begin
            phi1 = 1'b1; tick(3); phi1 = 1'b0; tick(3);
            phi2 = 1'b1; tick(3); phi2 = 1'b0; tick(3);
        end
        model_shift(b);
        vectors++;
        if (scan_out !== m_frame[F-1]) begin
            miscompares++;
            $display("FAIL scan_out got %b want %b", scan_out, m_frame[F-1]);
        end
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input logic coinc_alt);
        for (int i = n - 1; i >= 0; i--) shift_bit(v[i], coinc_alt && (i % 2 == 1));
    endtask

    task automatic pulse_load(input logic busy_now);
        model_load(busy_now);
        load = 1'b1; tick(3);
        load = 1'b0; tick(5);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(2);
        vectors++;
        if ({scan_out, wr_valid, busy, burst, err_len, err_ovf, wr_bank, wr_addr, wr_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want 0", {scan_out, wr_valid, busy, burst, err_len, err_ovf, wr_bank, wr_addr, wr_data});
        end
        rst_n = 1'b1; model_reset(); tick(1);
    endtask

    task automatic test_single();
        send_bits({10'd0, 1'b0, 2'd0, 11'h123, 8'hA5}, F, 1'b0);
        pulse_load(1'b0);
        vectors++;
        if (exp_q.size() != 0 || wr_addr !== 11'h123 || wr_data !== 8'hA5 || wr_bank !== 2'd0) begin
            miscompares++;
            $display("FAIL single_write got %h/%h/%h pend=%0d want 0/123/a5", wr_bank, wr_addr, wr_data, exp_q.size());
        end
        vectors++;
        if ({burst, err_len, err_ovf, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_flags got %b want 0000", {burst, err_len, err_ovf, busy});
        end
        // Random frame with coincident phi1/phi2 edges on alternate bits.
        send_bits({10'd0, 1'b0, BW'($urandom), AW'($urandom), DW'($urandom)}, F, 1'b1);
        pulse_load(1'b0);
        vectors++;
        if (exp_q.size() != 0 || burst !== m_burst) begin
            miscompares++;
            $display("FAIL coincident_frame pend=%0d burst=%b want 0/%b", exp_q.size(), burst, m_burst);
        end
    endtask

    task automatic test_burst();
        logic [DW-1:0] d [3];
        d[0] = 8'h22; d[1] = 8'h33; d[2] = 8'h44;
        send_bits({10'd0, 1'b1, 2'd2, 11'h7FF, 8'h11}, F, 1'b0);
        pulse_load(1'b0);
        for (int k = 0; k < 3; k++) begin
            send_bits({24'd0, d[k]}, DW, 1'b0);
            pulse_load(1'b0);
            vectors++;
            if (burst !== 1'b1 || exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL burst_step%0d burst=%b pend=%0d want 1/0", k, burst, exp_q.size());
            end
        end
        vectors++;
        if (wr_bank !== 2'd2 || wr_addr !== 11'h002 || wr_data !== 8'h44) begin
            miscompares++;
            $display("FAIL burst_wrap got %h/%h/%h want 2/002/44", wr_bank, wr_addr, wr_data);
        end
        for (int k = 0; k < 2; k++) begin
            send_bits({24'd0, DW'($urandom)}, DW, 1'b0);
            pulse_load(1'b0);
        end
        send_bits({10'd0, 1'b0, BW'($urandom), AW'($urandom), DW'($urandom)}, F, 1'b0);
        pulse_load(1'b0);
        vectors++;
        if (burst !== 1'b0 || exp_q.size() != 0 || err_len !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_exit burst=%b pend=%0d err_len=%b want 0/0/0", burst, exp_q.size(), err_len);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        wr_ready = 1'b0;
        send_bits({10'd0, 1'b0, 2'd1, 11'h055, 8'h3C}, F, 1'b0);
        model_load(1'b0);
        load = 1'b1; lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #2;
            if (k == 3) load = 1'b0;
            if (wr_valid && lat == 0) lat = k;
        end
        vectors++;
        if (lat != SS + 2) begin
            miscompares++;
            $display("FAIL pad_latency got %0d want %0d", lat, SS + 2);
        end
        pulse_load(1'b1);
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (wr_valid !== 1'b1 || busy !== 1'b1 || {wr_bank, wr_addr, wr_data} !== {2'd1, 11'h055, 8'h3C}) begin
                miscompares++;
                $display("FAIL stall_stable got v=%b %h/%h/%h want 1 1/055/3c", wr_valid, wr_bank, wr_addr, wr_data);
            end
            tick(1);
        end
        vectors++;
        if (err_ovf !== m_err_ovf || err_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL err_ovf got %b want 1", err_ovf);
        end
        wr_ready = 1'b1; tick(4);
        vectors++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release pend=%0d busy=%b want 0/0", exp_q.size(), busy);
        end
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
        m_err_ovf = 1'b0; m_err_len = 1'b0;
        vectors++;
        if (err_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear got %b want 0", err_ovf);
        end
    endtask

    task automatic test_len_err();
        send_bits($urandom, 13, 1'b0);
        pulse_load(1'b0);
        vectors++;
        if (err_len !== 1'b1 || burst !== 1'b0 || wr_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL len13 got err=%b burst=%b v=%b want 1/0/0", err_len, burst, wr_valid);
        end
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
        m_err_len = 1'b0;
        vectors++;
        if (err_len !== 1'b0) begin
            miscompares++;
            $display("FAIL len_clear got %b want 0", err_len);
        end
        // DATA_W bits outside a burst, then an empty load, are both length errors.
        send_bits($urandom, DW, 1'b0);
        pulse_load(1'b0);
        pulse_load(1'b0);
        // A short load inside a burst terminates the burst.
        send_bits({10'd0, 1'b1, BW'($urandom), AW'($urandom), DW'($urandom)}, F, 1'b0);
        pulse_load(1'b0);
        send_bits($urandom, 5, 1'b0);
        pulse_load(1'b0);
        vectors++;
        if (err_len !== m_err_len || burst !== m_burst || burst !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL len_in_burst got err=%b burst=%b want %b/%b", err_len, burst, m_err_len, m_burst);
        end
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
        m_err_len = 1'b0;
    endtask

    task automatic test_reset_mid();
        send_bits($urandom, 12, 1'b0);
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        model_reset();
        vectors++;
        if ({scan_out, burst, err_len, wr_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset got %b want 0000", {scan_out, burst, err_len, wr_valid});
        end
        send_bits({10'd0, 1'b0, BW'($urandom), AW'($urandom), DW'($urandom)}, F, 1'b0);
        pulse_load(1'b0);
        vectors++;
        if (exp_q.size() != 0 || err_len !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_frame pend=%0d err_len=%b want 0/0", exp_q.size(), err_len);
        end
    endtask

    task automatic test_long_frame();
        send_bits($urandom, 25, 1'b0);
        pulse_load(1'b0);
        vectors++;
        if (exp_q.size() != 0 || err_len !== 1'b0 || burst !== m_burst) begin
            miscompares++;
            $display("FAIL long_frame pend=%0d err_len=%b burst=%b want 0/0/%b", exp_q.size(), err_len, burst, m_burst);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            send_bits({10'd0, 1'($urandom), BW'($urandom), AW'($urandom), DW'($urandom)}, F, 1'($urandom));
            pulse_load(1'b0);
            if (m_burst) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    send_bits({24'd0, DW'($urandom)}, DW, 1'b0);
                    pulse_load(1'b0);
                end
            end
            vectors++;
            if (exp_q.size() != 0 || burst !== m_burst || wr_addr !== m_addr || wr_bank !== m_bank) begin
                miscompares++;
                $display("FAIL random%0d got b=%b %h/%h want b=%b %h/%h", r, burst, wr_bank, wr_addr, m_burst, m_bank, m_addr);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_len_err();
        test_reset_mid();
        test_long_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
